spi_fsm: RTL and testbench

//  Transaction controller for the SPI memory datapath. Sequences the parallel-load

---
 rtl/spi_fsm.sv | 146 ++++++++++++++
 tb/tb_spi_fsm.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/spi_fsm.sv
// Transaction controller for the SPI memory datapath: address+R/W frame, then one write or read byte.
// Optional burst mode (auto-increment, repeated data bytes) is enabled by defining SPI_FSM_BURST_EN.
module spi_fsm #(
    parameter int WIDTH = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic cs_n,
    input  logic sclk_rise,
    input  logic rw_bit,
    output logic sr_pclk,
    output logic sr_pload,
    output logic addr_we,
    output logic dm_we,
    output logic miso_bufe,
    output logic addr_inc,
    output logic busy
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [3:0] {
        IDLE,
        GET_ADDR,
        GOT_ADDR,
        READ_WAIT,
        READ_LOAD,
        READ_SEND,
        WRITE_GET,
        WRITE_COMMIT,
        BURST_INC,
        DONE
    } state_t;

    state_t state;
    state_t nextState;
    logic [CW-1:0] bitCount;
    logic [CW-1:0] nextCount;
    logic shifting;
`ifdef SPI_FSM_BURST_EN
    logic burstRead;
`endif

    // Shift enable is the only combinational output; a deasserting cs_n suppresses it.
    assign shifting = (state == GET_ADDR) || (state == READ_SEND) || (state == WRITE_GET);
    assign sr_pclk  = sclk_rise & ~cs_n & shifting;

    always_comb begin
        nextState = state;
        nextCount = bitCount;
        if (state != IDLE && cs_n) begin
            nextState = IDLE;
            nextCount = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!cs_n) begin
                        nextState = GET_ADDR;
                        nextCount = '0;
                    end
                end
                GET_ADDR, WRITE_GET, READ_SEND: begin
                    if (sr_pclk) begin
                        if (bitCount == LAST_BIT) begin
                            nextCount = '0;
                            if (state == GET_ADDR) begin
                                nextState = GOT_ADDR;
                            end else if (state == WRITE_GET) begin
                                nextState = WRITE_COMMIT;
                            end else begin
`ifdef SPI_FSM_BURST_EN
                                nextState = BURST_INC;
`else
                                nextState = DONE;
`endif
                            end
                        end else begin
                            nextCount = bitCount + CW'(1);
                        end
                    end
                end
                GOT_ADDR: begin
                    nextState = rw_bit ? READ_WAIT : WRITE_GET;
                    nextCount = '0;
                end
                READ_WAIT: nextState = READ_LOAD;
                READ_LOAD: begin
                    nextState = READ_SEND;
                    nextCount = '0;
                end
                WRITE_COMMIT: begin
`ifdef SPI_FSM_BURST_EN
                    nextState = BURST_INC;
`else
                    nextState = DONE;
`endif
                end
                BURST_INC: begin
`ifdef SPI_FSM_BURST_EN
                    nextState = burstRead ? READ_WAIT : WRITE_GET;
                    nextCount = '0;
`else
                    nextState = IDLE;
`endif
                end
                DONE:    nextState = DONE;
                default: nextState = IDLE;
            endcase
        end
    end

    // Outputs are registered from the next state, so they track the current state exactly.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            bitCount  <= '0;
            sr_pload  <= 1'b0;
            addr_we   <= 1'b0;
            dm_we     <= 1'b0;
            miso_bufe <= 1'b0;
            addr_inc  <= 1'b0;
            busy      <= 1'b0;
`ifdef SPI_FSM_BURST_EN
            burstRead <= 1'b0;
`endif
        end else begin
            state     <= nextState;
            bitCount  <= nextCount;
            sr_pload  <= (nextState == READ_LOAD);
            addr_we   <= (nextState == GOT_ADDR);
            dm_we     <= (nextState == WRITE_COMMIT);
            miso_bufe <= (nextState == READ_SEND);
            busy      <= (nextState != IDLE);
`ifdef SPI_FSM_BURST_EN
            addr_inc  <= (nextState == BURST_INC);
            if (state == GOT_ADDR) begin
                burstRead <= rw_bit;
            end
`else
            addr_inc  <= 1'b0;
`endif
        end
    end

endmodule

// File: tb/tb_spi_fsm.sv
// Directed bench for spi_fsm: each step queues the outputs expected in that cycle;
// a negedge monitor pops and compares them against the DUT.
module tb_spi_fsm;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic cs_n = 1'b1;
    logic sclk_rise = 1'b0;
    logic rw_bit = 1'b0;
    logic sr_pclk, sr_pload, addr_we, dm_we, miso_bufe, addr_inc, busy;
    logic stimDone = 1'b0;

    int compared = 0;
    int mismatched = 0;

    typedef struct {
        string      tag;
        logic [6:0] val;
    } exp_t;
    exp_t expQ[$];

    // Output vector order: {sr_pclk, sr_pload, addr_we, dm_we, miso_bufe, addr_inc, busy}
    localparam logic [6:0] E_IDLE = 7'b0000000;
    localparam logic [6:0] E_BUSY = 7'b0000001;
    localparam logic [6:0] E_PCLK = 7'b1000000;
    localparam logic [6:0] E_LOAD = 7'b0100001;
    localparam logic [6:0] E_AWE  = 7'b0010001;
    localparam logic [6:0] E_DWE  = 7'b0001001;
    localparam logic [6:0] E_BUFE = 7'b0000101;
    localparam logic [6:0] E_INC  = 7'b0000011;

    spi_fsm #(.WIDTH(8)) dut (
        .clk(clk),
        .reset(reset),
        .cs_n(cs_n),
        .sclk_rise(sclk_rise),
        .rw_bit(rw_bit),
        .sr_pclk(sr_pclk),
        .sr_pload(sr_pload),
        .addr_we(addr_we),
        .dm_we(dm_we),
        .miso_bufe(miso_bufe),
        .addr_inc(addr_inc),
        .busy(busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (expQ.size() > 0) begin
            exp_t e;
            logic [6:0] obs;
            e = expQ.pop_front();
            obs = {sr_pclk, sr_pload, addr_we, dm_we, miso_bufe, addr_inc, busy};
            compared++;
            assert (obs === e.val) else begin
                mismatched++;
                $error("FAIL %s: observed %b expected %b (pclk,pload,awe,dwe,bufe,inc,busy)", e.tag, obs, e.val);
            end
        end
    end

    initial begin
        #100000;
        if (stimDone !== 1'b1) begin
            mismatched++;
            $error("FAIL timeout: stimulus did not complete within the wait limit");
            $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
            $finish;
        end
    end

    // One clock cycle: inputs driven shortly after the edge, expected outputs of that same cycle queued.
    task automatic step(input logic r, input logic cs, input logic rise, input logic rw,
                        input logic [6:0] expVal, input string tag);
        exp_t e;
        @(posedge clk);
        #2;
        reset = r;
        cs_n = cs;
        sclk_rise = rise;
        rw_bit = rw;
        e.tag = tag;
        e.val = expVal;
        expQ.push_back(e);
    endtask

    task automatic shiftBits(input int n, input logic [6:0] base, input string tag);
        for (int i = 0; i < n; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0, base, tag);
            step(1'b0, 1'b0, 1'b1, 1'b0, base | E_PCLK, tag);
        end
    endtask

    task automatic addrFrame(input logic [7:0] frame, input string tag);
        step(1'b0, 1'b0, 1'b0, 1'b0, E_IDLE, {tag, "_csfall"});
        shiftBits(8, E_BUSY, {tag, "_addr"});
        step(1'b0, 1'b0, 1'b0, frame[0], E_AWE, {tag, "_gotaddr"});
    endtask

    task automatic writeData(input string tag);
        shiftBits(8, E_BUSY, {tag, "_wdata"});
        step(1'b0, 1'b0, 1'b0, 1'b0, E_DWE, {tag, "_commit"});
    endtask

    task automatic doneRelease(input string tag);
        step(1'b0, 1'b0, 1'b1, 1'b0, E_BUSY, {tag, "_done_ign"});
        step(1'b0, 1'b1, 1'b0, 1'b0, E_BUSY, {tag, "_done_cs"});
        step(1'b0, 1'b1, 1'b0, 1'b0, E_IDLE, {tag, "_idle"});
    endtask

    initial begin
        // Reset state, with stray sclk_rise while deselected
        step(1'b1, 1'b1, 1'b1, 1'b0, E_IDLE, "reset0");
        step(1'b1, 1'b1, 1'b0, 1'b0, E_IDLE, "reset1");
        @(negedge clk);
        if ({sr_pclk, sr_pload, addr_we, dm_we, miso_bufe, addr_inc, busy} !== E_IDLE) begin
            mismatched++;
            $error("FAIL reset_state: outputs %b not all zero during reset",
                   {sr_pclk, sr_pload, addr_we, dm_we, miso_bufe, addr_inc, busy});
        end
        step(1'b0, 1'b1, 1'b1, 1'b0, E_IDLE, "idle_rise_ign");

        // Write 8'h2A then 8'hA5
        addrFrame(8'h2A, "wr");
        writeData("wr");
        doneRelease("wr");

        // Read 8'h2B
        addrFrame(8'h2B, "rd");
        step(1'b0, 1'b0, 1'b1, 1'b0, E_BUSY, "rd_wait");
        step(1'b0, 1'b0, 1'b0, 1'b0, E_LOAD, "rd_load");
        shiftBits(8, E_BUFE, "rd_send");
`ifdef SPI_FSM_BURST_EN
        step(1'b0, 1'b1, 1'b0, 1'b0, E_INC, "rd_binc_cs");
        step(1'b0, 1'b1, 1'b0, 1'b0, E_IDLE, "rd_idle");
`else
        doneRelease("rd");
`endif

        // Abort after 3 address rises, then a clean write
        step(1'b0, 1'b0, 1'b0, 1'b0, E_IDLE, "ab_csfall");
        shiftBits(3, E_BUSY, "ab_addr");
        step(1'b0, 1'b1, 1'b0, 1'b0, E_BUSY, "ab_cs");
        step(1'b0, 1'b1, 1'b0, 1'b0, E_IDLE, "ab_idle");
        addrFrame(8'h2A, "ab_wr");
        writeData("ab_wr");
        doneRelease("ab_wr");

        // Reset after 12 rises (4 into the write byte)
        addrFrame(8'h2A, "rs");
        shiftBits(4, E_BUSY, "rs_wdata");
        step(1'b1, 1'b0, 1'b0, 1'b0, E_BUSY, "rs_cycle");
        step(1'b0, 1'b1, 1'b1, 1'b0, E_IDLE, "rs_after");
        step(1'b0, 1'b1, 1'b1, 1'b0, E_IDLE, "rs_after2");

        // Burst-style stimulus: 8'h2A, 8'h11, 8'h22
        addrFrame(8'h2A, "bu");
        writeData("bu");
`ifdef SPI_FSM_BURST_EN
        step(1'b0, 1'b0, 1'b0, 1'b0, E_INC, "bu_inc");
        shiftBits(8, E_BUSY, "bu_wdata2");
        step(1'b0, 1'b1, 1'b0, 1'b0, E_DWE, "bu_commit2_cs");
        step(1'b0, 1'b1, 1'b0, 1'b0, E_IDLE, "bu_idle");
`else
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0, E_BUSY, "bu_done");
            step(1'b0, 1'b0, 1'b1, 1'b0, E_BUSY, "bu_done_rise");
        end
        step(1'b0, 1'b1, 1'b0, 1'b0, E_BUSY, "bu_done_cs");
        step(1'b0, 1'b1, 1'b0, 1'b0, E_IDLE, "bu_idle");
`endif

        // cs_n rising together with sclk_rise inside the write byte
        addrFrame(8'h2A, "co");
        shiftBits(5, E_BUSY, "co_wdata");
        step(1'b0, 1'b1, 1'b1, 1'b0, E_BUSY, "co_coincident");
        step(1'b0, 1'b1, 1'b0, 1'b0, E_IDLE, "co_idle");

        repeat (3) @(posedge clk);
        stimDone = 1'b1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
